// File: rtl/pulse_burst_sched_if.sv
// rtl/pulse_burst_sched_if.sv - configuration byte stream bundle for pulse_burst_sched
//
// Purpose: groups the configuration loading handshake of the burst scheduler.
// Signals:
//   i_cfg_valid  one-cycle strobe, i_cfg_byte holds a new configuration byte
//   i_cfg_byte   configuration byte, MSB-first stream
//   i_cfg_clear  strobe, discard table and re-enter loading
//   o_cfg_ready  high while the scheduler accepts configuration bytes
// Modports:
//   master  drives the byte stream (host / SPI side)
//   slave   receives the byte stream (scheduler side)

interface pulse_burst_sched_if;
  logic       i_cfg_valid;
  logic [7:0] i_cfg_byte;
  logic       i_cfg_clear;
  logic       o_cfg_ready;

  modport master (
    output i_cfg_valid,
    output i_cfg_byte,
    output i_cfg_clear,
    input  o_cfg_ready
  );

  modport slave (
    input  i_cfg_valid,
    input  i_cfg_byte,
    input  i_cfg_clear,
    output o_cfg_ready
  );
endinterface

// File: rtl/pulse_burst_sched.sv
// rtl/pulse_burst_sched.sv - table-driven pulse burst scheduler
//
// Purpose: loads a table of N_SLOTS burst profiles (HIGH duration, LOW
// duration, repeat count) from a byte stream, then plays the slots in order,
// emitting C pulses of max(H,1) high cycles and max(L,1) low cycles per slot,
// optionally looping over the table.
// Ports:
//   i_clk          system clock, rising edge
//   i_reset        synchronous active-low reset
//   cfg            configuration stream (slave modport of pulse_burst_sched_if)
//   i_start_nstop  level, 1 = run schedule, 0 = stop
//   i_loop         level, sampled at the end of the last slot: 1 = wrap
//   o_pulse        registered pulse output
//   o_busy         high in SETUP, HIGH, LOW
//   o_slot         slot currently executing (0 when idle)
//   o_done         one-cycle strobe when the schedule completes

module pulse_burst_sched #(
  parameter int N_SLOTS = 4,
  parameter int W_DUR   = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  pulse_burst_sched_if.slave         cfg,
  input  logic                       i_start_nstop,
  input  logic                       i_loop,
  output logic                       o_pulse,
  output logic                       o_busy,
  output logic [$clog2(N_SLOTS)-1:0] o_slot,
  output logic                       o_done
);

  localparam int SLOT_W = $clog2(N_SLOTS);
  localparam int BYTES  = 2 * W_DUR / 8 + 1;
  localparam int REC_W  = 8 * BYTES;
  localparam int BYTE_W = $clog2(BYTES);

  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(N_SLOTS - 1);
  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES - 1);

  typedef enum logic [2:0] {
    S_LOAD,
    S_IDLE,
    S_SETUP,
    S_HIGH,
    S_LOW
  } state_t;

  state_t              state_q, state_d;
  logic [SLOT_W-1:0]   slot_q, slot_d;
  logic [W_DUR-1:0]    phase_q, phase_d;
  logic [7:0]          reps_q, reps_d;
  logic                emitted_q, emitted_d;
  logic [SLOT_W-1:0]   load_slot_q, load_slot_d;
  logic [BYTE_W-1:0]   load_byte_q, load_byte_d;
  logic                pulse_q, pulse_d;
  logic                done_q, done_d;

  logic                tbl_shift;
  logic                tbl_zero;
  logic                finish;
  logic                advance;

  // Each record is {H, L, C}; bytes arrive MSB first so shifting left in
  // arrival order leaves H in the top bits and C in the bottom byte.
  logic [REC_W-1:0]    rec_q [N_SLOTS];

  logic [REC_W-1:0]    cur_rec;
  logic [W_DUR-1:0]    cur_h;
  logic [W_DUR-1:0]    cur_l;
  logic [7:0]          cur_c;

  assign cur_rec = rec_q[slot_q];
  assign cur_h   = cur_rec[REC_W-1 -: W_DUR];
  assign cur_l   = cur_rec[W_DUR+7 -: W_DUR];
  assign cur_c   = cur_rec[7:0];

  // Profile table
  always_ff @(posedge i_clk) begin
    if (!i_reset || tbl_zero) begin
      for (int s = 0; s < N_SLOTS; s++) begin
        rec_q[s] <= '0;
      end
    end else if (tbl_shift) begin
      rec_q[load_slot_q] <= {rec_q[load_slot_q][REC_W-9:0], cfg.i_cfg_byte};
    end
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q     <= S_LOAD;
      slot_q      <= '0;
      phase_q     <= '0;
      reps_q      <= '0;
      emitted_q   <= 1'b0;
      load_slot_q <= '0;
      load_byte_q <= '0;
      pulse_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      phase_q     <= phase_d;
      reps_q      <= reps_d;
      emitted_q   <= emitted_d;
      load_slot_q <= load_slot_d;
      load_byte_q <= load_byte_d;
      pulse_q     <= pulse_d;
      done_q      <= done_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    phase_d     = phase_q;
    reps_d      = reps_q;
    emitted_d   = emitted_q;
    load_slot_d = load_slot_q;
    load_byte_d = load_byte_q;
    tbl_shift   = 1'b0;
    tbl_zero    = 1'b0;
    finish      = 1'b0;
    advance     = 1'b0;

    case (state_q)
      S_LOAD: begin
        if (cfg.i_cfg_valid) begin
          tbl_shift = 1'b1;
          if (load_byte_q == LAST_BYTE) begin
            load_byte_d = '0;
            if (load_slot_q == LAST_SLOT) begin
              load_slot_d = '0;
              state_d     = S_IDLE;
            end else begin
              load_slot_d = load_slot_q + SLOT_W'(1);
            end
          end else begin
            load_byte_d = load_byte_q + BYTE_W'(1);
          end
        end
      end

      S_IDLE: begin
        if (cfg.i_cfg_clear) begin
          state_d     = S_LOAD;
          load_slot_d = '0;
          load_byte_d = '0;
          tbl_zero    = 1'b1;
        end else if (i_start_nstop) begin
          state_d   = S_SETUP;
          slot_d    = '0;
          emitted_d = 1'b0;
        end
      end

      S_SETUP: begin
        if (!i_start_nstop) begin
          state_d = S_IDLE;
          slot_d  = '0;
        end else begin
          reps_d  = cur_c;
          phase_d = cur_h;
          if (cur_c == 8'd0) begin
            advance = 1'b1;
          end else begin
            state_d   = S_HIGH;
            emitted_d = 1'b1;
          end
        end
      end

      S_HIGH: begin
        if (!i_start_nstop) begin
          state_d = S_IDLE;
          slot_d  = '0;
        end else if (phase_q <= W_DUR'(1)) begin
          // A zero duration still occupies one cycle.
          state_d = S_LOW;
          phase_d = cur_l;
        end else begin
          phase_d = phase_q - W_DUR'(1);
        end
      end

      S_LOW: begin
        if (!i_start_nstop) begin
          state_d = S_IDLE;
          slot_d  = '0;
        end else if (phase_q <= W_DUR'(1)) begin
          if (reps_q > 8'd1) begin
            reps_d  = reps_q - 8'd1;
            state_d = S_HIGH;
            phase_d = cur_h;
          end else begin
            reps_d  = '0;
            advance = 1'b1;
          end
        end else begin
          phase_d = phase_q - W_DUR'(1);
        end
      end

      default: begin
        state_d = S_LOAD;
      end
    endcase

    // Wrapping requires a pulse in the finished pass, so an all-zero-count
    // table always terminates instead of spinning through SETUP forever.
    if (advance) begin
      if (slot_q == LAST_SLOT) begin
        slot_d = '0;
        if (i_loop && emitted_q) begin
          state_d   = S_SETUP;
          emitted_d = 1'b0;
        end else begin
          state_d = S_IDLE;
          finish  = 1'b1;
        end
      end else begin
        slot_d  = slot_q + SLOT_W'(1);
        state_d = S_SETUP;
      end
    end
  end

  // Output logic: pulse and done are registered from next-state decode so
  // o_pulse is high exactly while the FSM sits in HIGH.
  always_comb begin
    pulse_d = (state_d == S_HIGH);
    done_d  = finish;
  end

  assign o_pulse         = pulse_q;
  assign o_done          = done_q;
  assign o_busy          = (state_q == S_SETUP) || (state_q == S_HIGH) || (state_q == S_LOW);
  assign o_slot          = slot_q;
  assign cfg.o_cfg_ready = (state_q == S_LOAD);

endmodule
